// File: rtl/host_cmd_parser.sv
// Host UART command parser: assembles 7-byte frames (sync, opcode, 4 argument bytes, XOR check)
// and hands one decoded SD/host command at a time to sd_fsm over a valid/ack handshake.
module host_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic        ex_clk,
  input  logic        reset,
  input  logic [7:0]  uart_rx_data,
  input  logic [7:0]  uart_ctrl,
  input  logic        cmd_ack,
  output logic        uart_cmd_en,
  output logic        cmd_is_host,
  output logic [5:0]  uart_cmd,
  output logic [3:0]  host_cmd,
  output logic [31:0] cmd_arg,
  output logic        software_reset,
  output logic        parse_err,
  output logic [2:0]  err_code
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [2:0] ERR_CHK   = 3'd1;
  localparam logic [2:0] ERR_CLASS = 3'd2;
  localparam logic [2:0] ERR_OVR   = 3'd3;
  localparam logic [2:0] ERR_FRAME = 3'd4;
  localparam logic [2:0] ERR_TOUT  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPCODE,
    S_ARG,
    S_CHECK,
    S_ISSUE
  } state_t;

  state_t            r_state;
  logic [1:0]        r_idx;
  logic [TO_W-1:0]   r_to;
  logic [7:0]        r_op;
  logic [7:0]        r_xor;
  logic [31:0]       r_arg_sh;

  logic              w_strb;
  logic              w_ferr;
  logic              w_in_frame;
  logic              w_to_hit;
  logic              w_unused_ctrl;

  assign w_strb        = uart_ctrl[0];
  assign w_ferr        = uart_ctrl[1];
  assign w_unused_ctrl = ^uart_ctrl[7:2];
  assign w_in_frame    = (r_state == S_OPCODE) || (r_state == S_ARG) || (r_state == S_CHECK);
  assign w_to_hit      = (r_to == TO_W'(TIMEOUT_CYCLES - 1));

  // Frame shadow registers carry data only; their contents are irrelevant until rewritten.
  always_ff @(posedge ex_clk) begin
    if (w_strb && !w_ferr) begin
      if (r_state == S_OPCODE) begin
        r_op  <= uart_rx_data;
        r_xor <= uart_rx_data;
      end else if (r_state == S_ARG) begin
        r_arg_sh <= {r_arg_sh[23:0], uart_rx_data};
        r_xor    <= r_xor ^ uart_rx_data;
      end
    end
  end

  always_ff @(posedge ex_clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_idx          <= 2'd0;
      r_to           <= '0;
      uart_cmd_en    <= 1'b0;
      cmd_is_host    <= 1'b0;
      uart_cmd       <= 6'd0;
      host_cmd       <= 4'd0;
      cmd_arg        <= 32'd0;
      software_reset <= 1'b0;
      parse_err      <= 1'b0;
      err_code       <= 3'd0;
    end else begin
      software_reset <= 1'b0;
      parse_err      <= 1'b0;
      // Inter-byte timer only runs while a frame is partially received.
      if (w_strb || !w_in_frame) begin
        r_to <= '0;
      end else begin
        r_to <= r_to + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_strb) begin
            if (w_ferr) begin
              parse_err <= 1'b1;
              err_code  <= ERR_FRAME;
            end else if (uart_rx_data == SYNC_BYTE) begin
              r_state <= S_OPCODE;
            end
          end
        end
        S_OPCODE, S_ARG, S_CHECK: begin
          if (w_strb && w_ferr) begin
            parse_err <= 1'b1;
            err_code  <= ERR_FRAME;
            r_state   <= S_IDLE;
          end else if (w_strb) begin
            if (r_state == S_OPCODE) begin
              r_idx   <= 2'd3;
              r_state <= S_ARG;
            end else if (r_state == S_ARG) begin
              r_idx <= r_idx - 2'd1;
              if (r_idx == 2'd0) r_state <= S_CHECK;
            end else if (uart_rx_data != r_xor) begin
              parse_err <= 1'b1;
              err_code  <= ERR_CHK;
              r_state   <= S_IDLE;
            end else if (r_op[7:6] == 2'b11) begin
              parse_err <= 1'b1;
              err_code  <= ERR_CLASS;
              r_state   <= S_IDLE;
            end else if (r_op[7:6] == 2'b10) begin
              software_reset <= 1'b1;
              r_state        <= S_IDLE;
            end else begin
              uart_cmd_en <= 1'b1;
              cmd_is_host <= (r_op[7:6] == 2'b00);
              uart_cmd    <= (r_op[7:6] == 2'b01) ? r_op[5:0] : 6'd0;
              host_cmd    <= (r_op[7:6] == 2'b00) ? r_op[3:0] : 4'd0;
              cmd_arg     <= r_arg_sh;
              r_state     <= S_ISSUE;
            end
          end else if (w_to_hit) begin
            parse_err <= 1'b1;
            err_code  <= ERR_TOUT;
            r_state   <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (w_strb) begin
            parse_err <= 1'b1;
            err_code  <= w_ferr ? ERR_FRAME : ERR_OVR;
          end
          if (cmd_ack) begin
            uart_cmd_en <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_cmd_parser.sv
// Scoreboard bench for host_cmd_parser: a frame-buffer reference model queues expected
// events per input cycle; a negedge monitor pops and compares whenever the DUT emits one.
module tb_host_cmd_parser;

  localparam int TOUT = 16;

  logic        clk;
  logic        reset;
  logic [7:0]  uart_rx_data;
  logic [7:0]  uart_ctrl;
  logic        cmd_ack;
  logic        uart_cmd_en;
  logic        cmd_is_host;
  logic [5:0]  uart_cmd;
  logic [3:0]  host_cmd;
  logic [31:0] cmd_arg;
  logic        software_reset;
  logic        parse_err;
  logic [2:0]  err_code;

  host_cmd_parser #(.TIMEOUT_CYCLES(TOUT), .TO_W(5)) dut (
    .ex_clk        (clk),
    .reset         (reset),
    .uart_rx_data  (uart_rx_data),
    .uart_ctrl     (uart_ctrl),
    .cmd_ack       (cmd_ack),
    .uart_cmd_en   (uart_cmd_en),
    .cmd_is_host   (cmd_is_host),
    .uart_cmd      (uart_cmd),
    .host_cmd      (host_cmd),
    .cmd_arg       (cmd_arg),
    .software_reset(software_reset),
    .parse_err     (parse_err),
    .err_code      (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [2:0]  code;
    logic        host;
    logic [5:0]  uc;
    logic [3:0]  hc;
    logic [31:0] arg;
  } ev_t;

  ev_t q_err[$];
  ev_t q_swr[$];
  ev_t q_cmd[$];
  ev_t q_rel[$];

  int n_cmp = 0;
  int n_bad = 0;
  int ecnt  = 0;

  // Reference model state: bytes of the frame collected so far, pending flag, quiet cycles.
  logic [7:0] m_frame[$];
  bit         m_pend  = 1'b0;
  int         m_quiet = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT produced an event the model did not expect (edge %0d)", nm, ecnt);
  endtask

  function automatic ev_t mk_ev(input logic [2:0] code);
    ev_t e;
    e.cyc  = ecnt;
    e.code = code;
    e.host = 1'b0;
    e.uc   = 6'd0;
    e.hc   = 4'd0;
    e.arg  = 32'd0;
    return e;
  endfunction

  task automatic finish_frame();
    logic [7:0]  op;
    logic [7:0]  x;
    logic [31:0] arg;
    ev_t         e;
    op  = m_frame[1];
    arg = {m_frame[2], m_frame[3], m_frame[4], m_frame[5]};
    x   = m_frame[1] ^ m_frame[2] ^ m_frame[3] ^ m_frame[4] ^ m_frame[5];
    if (m_frame[6] != x) q_err.push_back(mk_ev(3'd1));
    else if (op[7:6] == 2'b11) q_err.push_back(mk_ev(3'd2));
    else if (op[7:6] == 2'b10) q_swr.push_back(mk_ev(3'd0));
    else begin
      e      = mk_ev(3'd0);
      e.host = (op[7:6] == 2'b00);
      e.uc   = e.host ? 6'd0 : op[5:0];
      e.hc   = e.host ? op[3:0] : 4'd0;
      e.arg  = arg;
      q_cmd.push_back(e);
      m_pend = 1'b1;
    end
    m_frame.delete();
  endtask

  task automatic model_step(input bit r, input bit s, input bit fe, input logic [7:0] d, input bit a);
    if (r) begin
      if (m_pend) q_rel.push_back(mk_ev(3'd0));
      m_pend  = 1'b0;
      m_quiet = 0;
      m_frame.delete();
    end else if (m_pend) begin
      if (s) q_err.push_back(mk_ev(fe ? 3'd4 : 3'd3));
      if (a) begin
        m_pend = 1'b0;
        q_rel.push_back(mk_ev(3'd0));
      end
    end else if (m_frame.size() == 0) begin
      if (s && fe) q_err.push_back(mk_ev(3'd4));
      else if (s && d == 8'hA5) begin
        m_frame.push_back(d);
        m_quiet = 0;
      end
    end else if (s) begin
      if (fe) begin
        q_err.push_back(mk_ev(3'd4));
        m_frame.delete();
      end else begin
        m_frame.push_back(d);
        m_quiet = 0;
        if (m_frame.size() == 7) finish_frame();
      end
    end else begin
      m_quiet++;
      if (m_quiet == TOUT) begin
        q_err.push_back(mk_ev(3'd5));
        m_frame.delete();
      end
    end
  endtask

  // One clock of stimulus; with chk0 the outputs are first checked to be all-zero (post-reset).
  task automatic tick(input bit s, input bit fe, input logic [7:0] d, input bit a, input bit r,
                      input bit chk0 = 1'b0);
    @(negedge clk);
    if (chk0) begin
      chk("rst_en",   {63'd0, uart_cmd_en}, 64'd0);
      chk("rst_host", {63'd0, cmd_is_host}, 64'd0);
      chk("rst_cmds", {54'd0, uart_cmd, host_cmd}, 64'd0);
      chk("rst_arg",  {32'd0, cmd_arg}, 64'd0);
      chk("rst_pulses", {60'd0, software_reset, parse_err, 2'd0}, 64'd0);
      chk("rst_errcode", {61'd0, err_code}, 64'd0);
    end
    reset        = r;
    uart_ctrl    = {6'($urandom), fe, s};
    uart_rx_data = s ? d : 8'($urandom);
    cmd_ack      = a;
    @(posedge clk);
    ecnt++;
    model_step(r, s, fe, d, a);
  endtask

  task automatic idle(input int n, input bit rnd_ack = 1'b0);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, rnd_ack && ($urandom_range(0, 2) == 0), 1'b0);
  endtask

  task automatic sb(input logic [7:0] b);
    tick(1'b1, 1'b0, b, 1'b0, 1'b0);
  endtask

  task automatic frame(input logic [7:0] op, a3, a2, a1, a0, c);
    sb(8'hA5); sb(op); sb(a3); sb(a2); sb(a1); sb(a0); sb(c);
  endtask

  // Monitor: pops the matching expectation whenever the DUT presents an event.
  bit  mon_prev_en = 1'b0;
  ev_t mon_cur;
  always @(negedge clk) begin
    ev_t e;
    if (ecnt > 0) begin
      if (parse_err === 1'b1) begin
        if (q_err.size() == 0) unexpected("parse_err");
        else begin
          e = q_err.pop_front();
          chk("err_cycle", 64'(ecnt), 64'(e.cyc));
          chk("err_code", {61'd0, err_code}, {61'd0, e.code});
        end
      end
      if (software_reset === 1'b1) begin
        if (q_swr.size() == 0) unexpected("software_reset");
        else begin
          e = q_swr.pop_front();
          chk("swr_cycle", 64'(ecnt), 64'(e.cyc));
        end
      end
      if (uart_cmd_en === 1'b1 && !mon_prev_en) begin
        if (q_cmd.size() == 0) unexpected("cmd_en_rise");
        else begin
          e = q_cmd.pop_front();
          mon_cur = e;
          chk("cmd_cycle", 64'(ecnt), 64'(e.cyc));
        end
      end
      if (uart_cmd_en === 1'b1) begin
        chk("cmd_fields", {21'd0, cmd_is_host, uart_cmd, host_cmd, cmd_arg},
            {21'd0, mon_cur.host, mon_cur.uc, mon_cur.hc, mon_cur.arg});
      end
      if (uart_cmd_en !== 1'b1 && mon_prev_en) begin
        if (q_rel.size() == 0) unexpected("cmd_en_fall");
        else begin
          e = q_rel.pop_front();
          chk("release_cycle", 64'(ecnt), 64'(e.cyc));
        end
      end
      mon_prev_en = (uart_cmd_en === 1'b1);
    end
  end

  initial begin
    reset        = 1'b1;
    uart_rx_data = 8'h00;
    uart_ctrl    = 8'h00;
    cmd_ack      = 1'b0;
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(2);

    // SD command held five cycles until ack.
    frame(8'h51, 8'h00, 8'h00, 8'h02, 8'h00, 8'h53);
    idle(4);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);

    // Leading junk dropped; host command acked in its first valid cycle.
    sb(8'h00); sb(8'hFF);
    frame(8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);

    // Software reset, bad class, bad checksum, back to back.
    frame(8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80);
    frame(8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0);
    frame(8'h51, 8'h00, 8'h00, 8'h02, 8'h00, 8'h52);
    idle(2);

    // Overrun while pending, then overrun coinciding with ack.
    frame(8'h51, 8'h00, 8'h00, 8'h02, 8'h00, 8'h53);
    idle(1);
    sb(8'h11);
    idle(2);
    tick(1'b1, 1'b0, 8'h11, 1'b1, 1'b0);
    idle(2);

    // Timeout after A5 51, then a full frame is accepted.
    sb(8'hA5); sb(8'h51);
    idle(TOUT + 3);
    frame(8'h4A, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h4A ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Framing error on A2, then recovery.
    sb(8'hA5); sb(8'h51); sb(8'h00);
    tick(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    frame(8'h07, 8'h12, 8'h34, 8'h56, 8'h78, 8'h07 ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
    idle(1);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-argument: remaining bytes must not complete the frame.
    sb(8'hA5); sb(8'h51); sb(8'h00);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    sb(8'h00); sb(8'h02); sb(8'h00); sb(8'h53);
    idle(3);

    // Reset while a command is pending.
    frame(8'h51, 8'h00, 8'h00, 8'h02, 8'h00, 8'h53);
    idle(2);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Randomized frames: random classes, corrupted checksums, framing errors, gaps, resets.
    for (int f = 0; f < 300; f++) begin
      logic [7:0] fr[7];
      int         bad_pos;
      fr[0] = 8'hA5;
      for (int k = 1; k < 6; k++) fr[k] = 8'($urandom);
      fr[6] = fr[1] ^ fr[2] ^ fr[3] ^ fr[4] ^ fr[5];
      if ($urandom_range(0, 7) == 0) fr[6] = fr[6] ^ 8'($urandom_range(1, 255));
      bad_pos = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1;
      if ($urandom_range(0, 3) == 0) sb(8'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      end
      for (int k = 0; k < 7; k++) begin
        tick(1'b1, (k == bad_pos), fr[k], ($urandom_range(0, 5) == 0), 1'b0);
        if ($urandom_range(0, 24) == 0) idle($urandom_range(TOUT - 2, TOUT + 3), 1'b1);
        else idle($urandom_range(0, 2), 1'b1);
      end
      idle($urandom_range(0, 4), 1'b1);
    end

    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);
    chk("leftover_err",  64'(q_err.size()), 64'd0);
    chk("leftover_swr",  64'(q_swr.size()), 64'd0);
    chk("leftover_cmd",  64'(q_cmd.size()), 64'd0);
    chk("leftover_rel",  64'(q_rel.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/host_cmd_parser.md
# host_cmd_parser

Byte-stream command parser between the host UART receiver and `sd_fsm`. Collects fixed 7-byte frames from `uart_rx_data`/`uart_ctrl`, checks sync, class and XOR checksum, and presents one decoded command (`uart_cmd`/`host_cmd` plus 32-bit argument) to `sd_fsm` with a valid/ack handshake. Also generates the `software_reset` pulse, and reports malformed, overrun or timed-out frames.

## Interface
- `TIMEOUT_CYCLES`, 1000000: max `ex_clk` cycles between bytes inside a frame.
- `TO_W`, 20: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- `ex_clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `uart_rx_data`  in  8  received byte; valid only while `uart_ctrl[0]`=1.
- `uart_ctrl`  in  8  [0] byte strobe (1 cycle); [1] framing error on that byte; [7:2] ignored.
- `cmd_ack`  in  1  from `sd_fsm`: pending command consumed.
- `uart_cmd_en`  out  1  command valid; held until acked.
- `cmd_is_host`  out  1  1 = `host_cmd` valid, 0 = `uart_cmd` valid.
- `uart_cmd`  out  6  SD command index.
- `host_cmd`  out  4  host-level command code.
- `cmd_arg`  out  32  command argument.
- `software_reset`  out  1  one-cycle pulse.
- `parse_err`  out  1  one-cycle error pulse.
- `err_code`  out  3  reason, valid with `parse_err`; holds last value.

## Operation
- Frame: `0xA5`, OP, A3, A2, A1, A0 (argument MSB first), CHK. CHK = OP^A3^A2^A1^A0.
- OP[7:6] class: 00 host command (`host_cmd`=OP[3:0]); 01 SD command (`uart_cmd`=OP[5:0]); 10 software reset; 11 invalid.
- States: IDLE, OPCODE, ARG (2-bit index 3..0), CHECK, ISSUE.
- IDLE: strobe with byte `0xA5` goes to OPCODE; any other byte is dropped silently.
- OPCODE: latch OP and go to ARG with idx=3.
- ARG: shift the byte into `cmd_arg` shadow; idx 0 goes to CHECK.
- CHECK, on strobe:
  - Checksum mismatch: err 1, go to IDLE.
  - Class 11: err 2, go to IDLE.
  - Class 10: `software_reset` pulse, go to IDLE.
  - Class 00/01: load outputs, assert `uart_cmd_en`, go to ISSUE.
  - Checksum is tested before class.
- ISSUE: `uart_cmd_en`=1 and outputs stable. When `cmd_ack`=1, deassert and go to IDLE.
- A strobe received in ISSUE is discarded and gives err 3 (overrun). The state remains ISSUE.
- Framing error (`uart_ctrl[1]`=1 with strobe): byte discarded, err 4.
  - OPCODE/ARG/CHECK go to IDLE.
  - IDLE and ISSUE keep their state.
- Timeout: the counter clears on every strobe and on state entry, and counts only in OPCODE/ARG/CHECK. When count = TIMEOUT_CYCLES-1 with no strobe: err 5, go to IDLE.
- Error codes: 1 checksum, 2 bad class, 3 overrun, 4 framing, 5 timeout.
- Unused output fields: class 00 sets `uart_cmd`=0; class 01 sets `host_cmd`=0. Class 10 leaves `uart_cmd`, `host_cmd`, `cmd_arg` unchanged.

## Timing
- Reset is synchronous and takes priority over all other inputs. It forces IDLE, clears the counter and index, and sets every output to 0. A frame or pending command in progress at reset is lost.
- All outputs are registered.
- If the CHECK strobe is at cycle N, then `uart_cmd_en`, `software_reset` or `parse_err` is first high at N+1.
- `cmd_ack` sampled high at cycle M (with `uart_cmd_en`=1) gives `uart_cmd_en`=0 at M+1. `cmd_ack` high at N+1 gives exactly one valid cycle. `cmd_ack` is ignored while `uart_cmd_en`=0.
- Strobe and `cmd_ack` in the same ISSUE cycle: err 3 pulse and return to IDLE. The byte is not parsed.
- A back-to-back next frame may start with a sync byte at N+1 (class 10/error cases) or after the ack cycle.
- `parse_err` is one cycle wide per event. `err_code` updates in the same cycle as the pulse.

## Test plan
- A5 51 00 00 02 00 53: `uart_cmd_en`=1 one cycle after CHK, `cmd_is_host`=0, `uart_cmd`=0x11, `cmd_arg`=0x00000200. Held 5 cycles until `cmd_ack`, then low next cycle.
- Bytes 00 FF A5 03 00 00 00 00 03: the leading 00 and FF are dropped silently. `cmd_is_host`=1, `host_cmd`=3, `cmd_arg`=0.
- A5 80 00 00 00 00 80: single-cycle `software_reset`, no `uart_cmd_en`. A5 C0 00 00 00 00 C0 gives err 2. A5 51 00 00 02 00 52 gives err 1.
- While pending, send byte 0x11: err 3, `uart_cmd_en` stays 1. Then strobe plus `cmd_ack` in the same cycle: err 3 and state IDLE.
- TIMEOUT_CYCLES=16: A5 51, then idle. Err 5 exactly 16 cycles after the last strobe, then a full valid frame is accepted. Framing error on the A2 byte gives err 4 and a return to IDLE.
- Assert `reset` for one cycle in the middle of ARG and also while in ISSUE: all outputs 0 next cycle. The partial frame is not completed by its remaining bytes.
